// File: rtl/mem_wb_pipe_pkg.sv
// Shared constants for the MEM-to-WB pipeline register.
package mem_wb_pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic ResetEnable  = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [DEF_DATA_W-1:0] ZeroWord           = '0;
  localparam logic [DEF_ADDR_W-1:0] NOPRegisterAddress = '0;

endpackage

// File: rtl/wb_stage_slot.sv
// One MEM-to-WB stage: {wdata, wd, wreg, hi, lo, whilo, valid}.
// Priority: rst > clear (load reset values) > hold > load.
module wb_stage_slot
  import mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              hold,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [ADDR_W-1:0] in_wd,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_hi,
  input  logic [DATA_W-1:0] in_lo,
  input  logic              in_whilo,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_wdata,
  output logic [ADDR_W-1:0] out_wd,
  output logic              out_wreg,
  output logic [DATA_W-1:0] out_hi,
  output logic [DATA_W-1:0] out_lo,
  output logic              out_whilo,
  output logic              out_valid
);

  // Stage register: reset/clear to an empty slot, hold, or capture the upstream entry
  always_ff @(posedge clk) begin
    if (rst == ResetEnable || clear) begin
      out_wdata <= DATA_W'(ZeroWord);
      out_wd    <= ADDR_W'(NOPRegisterAddress);
      out_wreg  <= WriteDisable;
      out_hi    <= DATA_W'(ZeroWord);
      out_lo    <= DATA_W'(ZeroWord);
      out_whilo <= WriteDisable;
      out_valid <= 1'b0;
    end else if (!hold) begin
      out_wdata <= in_wdata;
      out_wd    <= in_wd;
      out_wreg  <= in_wreg;
      out_hi    <= in_hi;
      out_lo    <= in_lo;
      out_whilo <= in_whilo;
      out_valid <= in_valid;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// Parametrised MEM-to-WB pipeline register with stall/bubble/flush control
// and a saturating count of retired register-file / HI-LO writes.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int STAGES = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_up,
  input  logic              stall_here,
  input  logic              flush,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              mem_whilo,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic              wb_whilo,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retired_cnt
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("mem_wb_pipe: STAGES must be in 1..4");
  end

  localparam int LAST = STAGES - 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [DATA_W-1:0] wdata_p [STAGES];
  logic [ADDR_W-1:0] wd_p    [STAGES];
  logic              wreg_p  [STAGES];
  logic [DATA_W-1:0] hi_p    [STAGES];
  logic [DATA_W-1:0] lo_p    [STAGES];
  logic              whilo_p [STAGES];
  logic              vld_p   [STAGES];

  logic [DATA_W-1:0] src_wdata [STAGES];
  logic [ADDR_W-1:0] src_wd    [STAGES];
  logic              src_wreg  [STAGES];
  logic [DATA_W-1:0] src_hi    [STAGES];
  logic [DATA_W-1:0] src_lo    [STAGES];
  logic              src_whilo [STAGES];
  logic              src_vld   [STAGES];
  logic [STAGES-1:0] clr;
  logic              retire_hit;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // MEM stalled while WB moves: inject a bubble so the held MEM entry is not emitted twice
      assign clr[k]       = flush | (stall_up & ~stall_here);
      assign src_wdata[k] = mem_wdata;
      assign src_wd[k]    = mem_wd;
      assign src_wreg[k]  = mem_wreg;
      assign src_hi[k]    = mem_hi;
      assign src_lo[k]    = mem_lo;
      assign src_whilo[k] = mem_whilo;
      assign src_vld[k]   = 1'b1;
    end else begin : g_body
      assign clr[k]       = flush;
      assign src_wdata[k] = wdata_p[k-1];
      assign src_wd[k]    = wd_p[k-1];
      assign src_wreg[k]  = wreg_p[k-1];
      assign src_hi[k]    = hi_p[k-1];
      assign src_lo[k]    = lo_p[k-1];
      assign src_whilo[k] = whilo_p[k-1];
      assign src_vld[k]   = vld_p[k-1];
    end

    // ---- stage k boundary ----
    wb_stage_slot #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .clear     (clr[k]),
      .hold      (stall_here),
      .in_wdata  (src_wdata[k]),
      .in_wd     (src_wd[k]),
      .in_wreg   (src_wreg[k]),
      .in_hi     (src_hi[k]),
      .in_lo     (src_lo[k]),
      .in_whilo  (src_whilo[k]),
      .in_valid  (src_vld[k]),
      .out_wdata (wdata_p[k]),
      .out_wd    (wd_p[k]),
      .out_wreg  (wreg_p[k]),
      .out_hi    (hi_p[k]),
      .out_lo    (lo_p[k]),
      .out_whilo (whilo_p[k]),
      .out_valid (vld_p[k])
    );
  end

  // The output stage is about to accept a real write entry this edge
  assign retire_hit = ~stall_here & ~clr[LAST] & src_vld[LAST] &
                      (src_wreg[LAST] | src_whilo[LAST]);

  // Saturating retired-write counter
  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      retired_cnt <= '0;
    end else if (retire_hit) begin
      retired_cnt <= sat_inc(retired_cnt);
    end
  end

  assign wb_wdata = wdata_p[LAST];
  assign wb_wd    = wd_p[LAST];
  assign wb_wreg  = wreg_p[LAST];
  assign wb_hi    = hi_p[LAST];
  assign wb_lo    = lo_p[LAST];
  assign wb_whilo = whilo_p[LAST];
  assign wb_valid = vld_p[LAST];

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe across several stage/counter configurations.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst, stall_up, stall_here, flush;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo;

  // STAGES=1
  logic [31:0] a_wdata, a_hi, a_lo, a_cnt;
  logic [4:0]  a_wd;
  logic        a_wreg, a_whilo, a_valid;
  // STAGES=3
  logic [31:0] b_wdata, b_hi, b_lo, b_cnt;
  logic [4:0]  b_wd;
  logic        b_wreg, b_whilo, b_valid;
  // STAGES=2
  logic [31:0] c_wdata, c_hi, c_lo, c_cnt;
  logic [4:0]  c_wd;
  logic        c_wreg, c_whilo, c_valid;
  // STAGES=1, CNT_W=4
  logic [31:0] d_wdata, d_hi, d_lo;
  logic [3:0]  d_cnt;
  logic [4:0]  d_wd;
  logic        d_wreg, d_whilo, d_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_pipe #(.STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .stall_up(stall_up), .stall_here(stall_here), .flush(flush),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .wb_wdata(a_wdata), .wb_wd(a_wd), .wb_wreg(a_wreg), .wb_hi(a_hi), .wb_lo(a_lo),
    .wb_whilo(a_whilo), .wb_valid(a_valid), .retired_cnt(a_cnt));

  mem_wb_pipe #(.STAGES(3)) u_s3 (
    .clk(clk), .rst(rst), .stall_up(stall_up), .stall_here(stall_here), .flush(flush),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .wb_wdata(b_wdata), .wb_wd(b_wd), .wb_wreg(b_wreg), .wb_hi(b_hi), .wb_lo(b_lo),
    .wb_whilo(b_whilo), .wb_valid(b_valid), .retired_cnt(b_cnt));

  mem_wb_pipe #(.STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .stall_up(stall_up), .stall_here(stall_here), .flush(flush),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .wb_wdata(c_wdata), .wb_wd(c_wd), .wb_wreg(c_wreg), .wb_hi(c_hi), .wb_lo(c_lo),
    .wb_whilo(c_whilo), .wb_valid(c_valid), .retired_cnt(c_cnt));

  mem_wb_pipe #(.STAGES(1), .CNT_W(4)) u_c4 (
    .clk(clk), .rst(rst), .stall_up(stall_up), .stall_here(stall_here), .flush(flush),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .wb_wdata(d_wdata), .wb_wd(d_wd), .wb_wreg(d_wreg), .wb_hi(d_hi), .wb_lo(d_lo),
    .wb_whilo(d_whilo), .wb_valid(d_valid), .retired_cnt(d_cnt));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    stall_up = 0; stall_here = 0; flush = 0;
    mem_wdata = '0; mem_wd = '0; mem_wreg = 0;
    mem_hi = '0; mem_lo = '0; mem_whilo = 0;
  endtask

  task automatic put(input logic [31:0] d, input logic [4:0] a, input logic we);
    mem_wdata = d; mem_wd = a; mem_wreg = we;
  endtask

  task automatic do_reset;
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    idle();
    put(32'hDEADBEEF, 5'd9, 1'b1);
    mem_whilo = 1; mem_hi = 32'h1234; mem_lo = 32'h5678;
    rst = 1;
    tick();
    tick();
    n_checks++;
    if ({a_wdata, a_wd, a_wreg, a_hi, a_lo, a_whilo, a_valid} !== '0) begin
      n_fail++; $display("FAIL reset_s1_outputs got %h %h %b %h %h %b %b want all zero",
                         a_wdata, a_wd, a_wreg, a_hi, a_lo, a_whilo, a_valid);
    end
    n_checks++;
    if (a_whilo !== 1'b0) begin
      n_fail++; $display("FAIL reset_whilo got %b want 0", a_whilo);
    end
    n_checks++;
    if (a_cnt !== 32'd0 || b_cnt !== 32'd0 || d_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_cnt got %0d %0d %0d want 0 0 0", a_cnt, b_cnt, d_cnt);
    end
    n_checks++;
    if (b_valid !== 1'b0 || c_valid !== 1'b0 || b_wreg !== 1'b0) begin
      n_fail++; $display("FAIL reset_multi got b_valid=%b c_valid=%b b_wreg=%b want 0",
                         b_valid, c_valid, b_wreg);
    end
    rst = 0;
    idle();
  endtask

  task automatic test_advance;
    do_reset();
    put(32'hDEADBEEF, 5'd5, 1'b1);
    tick();
    n_checks++;
    if (a_wdata !== 32'hDEADBEEF || a_wd !== 5'd5 || a_wreg !== 1'b1 || a_valid !== 1'b1) begin
      n_fail++; $display("FAIL adv_out got %h/%0d/%b/%b want deadbeef/5/1/1",
                         a_wdata, a_wd, a_wreg, a_valid);
    end
    n_checks++;
    if (a_cnt !== 32'd1) begin
      n_fail++; $display("FAIL adv_cnt got %0d want 1", a_cnt);
    end
    idle();
    tick();
    n_checks++;
    if (a_valid !== 1'b1 || a_wreg !== 1'b0 || a_cnt !== 32'd1) begin
      n_fail++; $display("FAIL adv_nowrite got valid=%b wreg=%b cnt=%0d want 1 0 1",
                         a_valid, a_wreg, a_cnt);
    end
  endtask

  task automatic test_latency;
    logic [31:0] exp_d [6];
    logic        exp_v [6];
    logic [31:0] exp_c [6];
    exp_d = '{0, 0, 1, 2, 3, 0};
    exp_v = '{0, 0, 1, 1, 1, 1};
    exp_c = '{0, 0, 1, 2, 3, 3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) put(i + 1, 5'(i + 1), 1'b1);
      else       put(0, 0, 1'b0);
      tick();
      n_checks++;
      if (b_wdata !== exp_d[i] || b_valid !== exp_v[i] || b_cnt !== exp_c[i]) begin
        n_fail++; $display("FAIL latency_cyc%0d got d=%0d v=%b cnt=%0d want d=%0d v=%b cnt=%0d",
                           i + 1, b_wdata, b_valid, b_cnt, exp_d[i], exp_v[i], exp_c[i]);
      end
    end
    idle();
  endtask

  task automatic test_bubble;
    do_reset();
    put(32'h77, 5'd7, 1'b1);
    tick();
    n_checks++;
    if (a_wd !== 5'd7 || a_wreg !== 1'b1 || a_valid !== 1'b1 || a_cnt !== 32'd1) begin
      n_fail++; $display("FAIL bubble_first got wd=%0d wreg=%b v=%b cnt=%0d want 7 1 1 1",
                         a_wd, a_wreg, a_valid, a_cnt);
    end
    stall_up = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (a_wreg !== 1'b0 || a_valid !== 1'b0 || a_wd !== 5'd0 || a_cnt !== 32'd1) begin
        n_fail++; $display("FAIL bubble_cyc%0d got wreg=%b v=%b wd=%0d cnt=%0d want 0 0 0 1",
                           i, a_wreg, a_valid, a_wd, a_cnt);
      end
    end
    idle();
  endtask

  task automatic test_hold;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      put(32'd10 + i, 5'(10 + i), 1'b1);
      tick();
    end
    stall_here = 1;
    for (int i = 0; i < 4; i++) begin
      put(32'h99 + i, 5'(20 + i), 1'b1);
      tick();
      n_checks++;
      if (b_wdata !== 32'd10 || b_valid !== 1'b1 || b_cnt !== 32'd1) begin
        n_fail++; $display("FAIL hold_s3_cyc%0d got d=%0d v=%b cnt=%0d want 10 1 1",
                           i, b_wdata, b_valid, b_cnt);
      end
      n_checks++;
      if (a_wdata !== 32'd12 || a_wd !== 5'd12 || a_cnt !== 32'd3) begin
        n_fail++; $display("FAIL hold_s1_cyc%0d got d=%0d wd=%0d cnt=%0d want 12 12 3",
                           i, a_wdata, a_wd, a_cnt);
      end
    end
    stall_here = 0;
    put(32'd13, 5'd13, 1'b1);
    tick();
    n_checks++;
    if (b_wdata !== 32'd11 || b_cnt !== 32'd2) begin
      n_fail++; $display("FAIL hold_resume0 got d=%0d cnt=%0d want 11 2", b_wdata, b_cnt);
    end
    idle();
    tick();
    n_checks++;
    if (b_wdata !== 32'd12 || b_cnt !== 32'd3) begin
      n_fail++; $display("FAIL hold_resume1 got d=%0d cnt=%0d want 12 3", b_wdata, b_cnt);
    end
    tick();
    n_checks++;
    if (b_wdata !== 32'd13 || b_wd !== 5'd13 || b_cnt !== 32'd4) begin
      n_fail++; $display("FAIL hold_resume2 got d=%0d wd=%0d cnt=%0d want 13 13 4",
                         b_wdata, b_wd, b_cnt);
    end
    tick();
    n_checks++;
    if (b_wreg !== 1'b0 || b_valid !== 1'b1 || b_cnt !== 32'd4) begin
      n_fail++; $display("FAIL hold_resume3 got wreg=%b v=%b cnt=%0d want 0 1 4",
                         b_wreg, b_valid, b_cnt);
    end
  endtask

  task automatic test_flush_during_stall;
    do_reset();
    put(32'h21, 5'd1, 1'b1);
    tick();
    put(32'h22, 5'd2, 1'b0);
    mem_whilo = 1; mem_hi = 32'hA; mem_lo = 32'hB;
    tick();
    n_checks++;
    if (c_wdata !== 32'h21 || c_valid !== 1'b1 || c_cnt !== 32'd1) begin
      n_fail++; $display("FAIL flush_pre got d=%h v=%b cnt=%0d want 21 1 1",
                         c_wdata, c_valid, c_cnt);
    end
    flush = 1; stall_here = 1;
    put(32'h23, 5'd3, 1'b1);
    tick();
    n_checks++;
    if (c_valid !== 1'b0 || c_wreg !== 1'b0 || c_whilo !== 1'b0 || c_wdata !== 32'h0 ||
        c_cnt !== 32'd1) begin
      n_fail++; $display("FAIL flush_now got v=%b wreg=%b whilo=%b d=%h cnt=%0d want 0 0 0 0 1",
                         c_valid, c_wreg, c_whilo, c_wdata, c_cnt);
    end
    idle();
    tick();
    n_checks++;
    if (c_valid !== 1'b0 || c_whilo !== 1'b0 || c_hi !== 32'h0 || c_cnt !== 32'd1) begin
      n_fail++; $display("FAIL flush_next got v=%b whilo=%b hi=%h cnt=%0d want 0 0 0 1",
                         c_valid, c_whilo, c_hi, c_cnt);
    end
  endtask

  task automatic test_saturation;
    logic [3:0] exp_c;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      put(32'h0, 5'd0, 1'b0);
      mem_whilo = 1;
      mem_hi = 32'h100 + i * 3;
      mem_lo = ~(32'h100 + i * 3);
      exp_c = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      tick();
      n_checks++;
      if (d_cnt !== exp_c || d_whilo !== 1'b1 || d_wreg !== 1'b0) begin
        n_fail++; $display("FAIL sat_cnt_cyc%0d got cnt=%0d whilo=%b wreg=%b want %0d 1 0",
                           i, d_cnt, d_whilo, d_wreg, exp_c);
      end
      n_checks++;
      if (d_hi !== 32'h100 + i * 3 || d_lo !== ~(32'h100 + i * 3)) begin
        n_fail++; $display("FAIL sat_hilo_cyc%0d got hi=%h lo=%h want %h %h",
                           i, d_hi, d_lo, 32'h100 + i * 3, ~(32'h100 + i * 3));
      end
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_advance();
    test_latency();
    test_bubble();
    test_hold();
    test_flush_during_stall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM-to-WB pipeline register. Replaces the plain MEM/WB latch between the memory-access stage and the register-file/HI-LO write-back.
- Adds a configurable stage count, a stall/bubble protocol driven by the pipeline controller, flush, and per-stage valid tracking.
- Adds a saturating retired-write counter for performance monitoring.

Parameters:
- DATA_W, 32, width of GPR write data and of HI/LO.
- ADDR_W, 5, width of GPR destination address.
- STAGES, 1, number of chained register stages (legal values 1..4); equals the MEM-to-WB latency.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stall_up  in  1  MEM stage stalled (controller stall bit for MEM).
- stall_here  in  1  WB side stalled (controller stall bit for WB); holds every stage.
- flush  in  1  pipeline flush (exception/eret).
- mem_wdata  in  DATA_W  GPR write data from MEM.
- mem_wd  in  ADDR_W  GPR destination address.
- mem_wreg  in  1  GPR write enable.
- mem_hi  in  DATA_W  HI write data.
- mem_lo  in  DATA_W  LO write data.
- mem_whilo  in  1  HI/LO write enable.
- wb_wdata  out  DATA_W  GPR write data to register file.
- wb_wd  out  ADDR_W  GPR destination address.
- wb_wreg  out  1  GPR write enable.
- wb_hi  out  DATA_W  HI data.
- wb_lo  out  DATA_W  LO data.
- wb_whilo  out  1  HI/LO write enable.
- wb_valid  out  1  final stage holds a real (non-bubble) instruction.
- retired_cnt  out  CNT_W  saturating count of emitted writes.

Behaviour:
- All outputs are registered; nothing combinational from input to output.
- Reset (rst=1 at posedge), for every stage: data=0, addr=0, wreg=0, whilo=0, valid=0. retired_cnt=0.
  - whilo resets to 0 (disabled), not enabled.
- Priority per posedge: rst > flush > stall_here > bubble > advance.
- flush=1: every stage loaded with the reset values. retired_cnt unchanged.
  - flush with stall_here=1: flush still wins.
- stall_here=1 (no flush): every stage holds its contents. Inputs are ignored. retired_cnt does not increment.
- stall_up=1 and stall_here=0: stage 0 loads a bubble (reset values, valid=0); stages 1..STAGES-1 shift forward.
  - Prevents a stalled MEM instruction writing back twice.
- Otherwise advance: stage 0 captures all mem_* inputs with valid=1; stage k captures stage k-1.
- Outputs = final stage (STAGES-1). Latency from a MEM capture to a wb_* appearance is exactly STAGES cycles.
- wb_wreg and wb_whilo are never 1 while wb_valid=0; bubbles and flushes clear both enables.
- wb_wdata/wb_wd are passed through unmodified even when wb_wreg=0. wd=0 writes are not filtered here.
- retired_cnt increments by 1 on each posedge where:
  - the output stage is about to present a new entry (not held by stall_here, no flush, no rst), and
  - that entry has valid=1 and (wreg|whilo)=1.
  - It saturates at all-ones with no wrap.
- Illegal STAGES outside 1..4: elaboration error via generate-time check.

Decomposition:
- Shared package/include: ResetEnable, WriteEnable/WriteDisable, ZeroWord, NOPRegisterAddress, and the default widths for DATA_W/ADDR_W.
- Sub-module wb_stage_slot: one stage of {data, addr, wreg, hi, lo, whilo, valid} with hold/clear/load controls, instantiated STAGES times in a generate loop.
- The top module holds the priority decode and the counter.

Test Plan:
- Reset then advance, STAGES=1: apply mem_wdata=0xDEADBEEF, wd=5, wreg=1 for one cycle → after 1 clk wb_wdata=0xDEADBEEF, wb_wd=5, wb_wreg=1, wb_valid=1, retired_cnt=1. During reset all outputs are 0 and wb_whilo=0.
- Latency, STAGES=3: issue wdata=1,2,3 on consecutive cycles → wb_wdata shows 1,2,3 starting exactly 3 cycles after the first capture; retired_cnt=3.
- Bubble: stall_up=1, stall_here=0 for 2 cycles with mem_wreg=1, wd=7 held → one instance of wd=7 emerges, followed by 2 bubble cycles (wb_wreg=0, wb_valid=0); retired_cnt grows by 1 only.
- Hold: stall_here=1 for 4 cycles with changing inputs → wb_* frozen at prior value; retired_cnt constant; after release the pipeline resumes with no loss or duplication.
- Flush during stall, STAGES=2, both stages valid: flush=1 with stall_here=1 → next cycle wb_valid=0, wb_wreg=0, wb_whilo=0, and the following cycle is also a bubble; retired_cnt unchanged.
- Saturation, CNT_W=4: 20 consecutive valid writes with whilo=1, wreg=0 → retired_cnt stops at 15 and stays there; wb_hi/wb_lo track the inputs.
